// File: rtl/baw_card_eval.sv
// Card evaluator: black/white card counts for two players, round comparison and
// a 16-bit MSB-first priority encoder. Every output is registered.
module baw_card_eval (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [8:0]  p1_card,
    input  logic [8:0]  p2_card,
    input  logic [3:0]  p1_handcard,
    input  logic [3:0]  p2_handcard,
    input  logic [15:0] enc_in,
    output logic [3:0]  p1_black,
    output logic [3:0]  p1_white,
    output logic [3:0]  p2_black,
    output logic [3:0]  p2_white,
    output logic [1:0]  matchresult,
    output logic [3:0]  enc_out,
    output logic        enc_valid
);

    logic [3:0] p1_black_d, p1_black_q;
    logic [3:0] p1_white_d, p1_white_q;
    logic [3:0] p2_black_d, p2_black_q;
    logic [3:0] p2_white_d, p2_white_q;
    logic [1:0] matchresult_d, matchresult_q;
    logic [3:0] enc_out_d, enc_out_q;
    logic       enc_valid_d, enc_valid_q;

    // Odd card values are black, even values white.
    always_comb begin
        p1_black_d = {3'b000, p1_card[1]} + {3'b000, p1_card[3]}
                   + {3'b000, p1_card[5]} + {3'b000, p1_card[7]};
        p1_white_d = {3'b000, p1_card[0]} + {3'b000, p1_card[2]}
                   + {3'b000, p1_card[4]} + {3'b000, p1_card[6]}
                   + {3'b000, p1_card[8]};
        p2_black_d = {3'b000, p2_card[1]} + {3'b000, p2_card[3]}
                   + {3'b000, p2_card[5]} + {3'b000, p2_card[7]};
        p2_white_d = {3'b000, p2_card[0]} + {3'b000, p2_card[2]}
                   + {3'b000, p2_card[4]} + {3'b000, p2_card[6]}
                   + {3'b000, p2_card[8]};
    end

    always_comb begin
        matchresult_d = 2'b00;
        if (p1_handcard > p2_handcard) begin
            matchresult_d = 2'b01;
        end else if (p2_handcard > p1_handcard) begin
            matchresult_d = 2'b10;
        end
    end

    // Ascending scan so the highest set bit is the last one to win.
    always_comb begin
        enc_out_d   = 4'd0;
        enc_valid_d = |enc_in;
        for (int i = 0; i < 16; i++) begin
            if (enc_in[i]) begin
                enc_out_d = 4'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            p1_black_q    <= 4'd0;
            p1_white_q    <= 4'd0;
            p2_black_q    <= 4'd0;
            p2_white_q    <= 4'd0;
            matchresult_q <= 2'b00;
            enc_out_q     <= 4'd0;
            enc_valid_q   <= 1'b0;
        end else begin
            p1_black_q    <= p1_black_d;
            p1_white_q    <= p1_white_d;
            p2_black_q    <= p2_black_d;
            p2_white_q    <= p2_white_d;
            matchresult_q <= matchresult_d;
            enc_out_q     <= enc_out_d;
            enc_valid_q   <= enc_valid_d;
        end
    end

    assign p1_black    = p1_black_q;
    assign p1_white    = p1_white_q;
    assign p2_black    = p2_black_q;
    assign p2_white    = p2_white_q;
    assign matchresult = matchresult_q;
    assign enc_out     = enc_out_q;
    assign enc_valid   = enc_valid_q;

endmodule

// File: tb/tb_baw_card_eval.sv
// Self-checking bench for baw_card_eval: directed vector table, reset and
// latency sequences, then randomized traffic against a reference model.
module tb_baw_card_eval;

    logic        clk;
    logic        reset_n;
    logic [8:0]  p1_card, p2_card;
    logic [3:0]  p1_handcard, p2_handcard;
    logic [15:0] enc_in;
    logic [3:0]  p1_black, p1_white, p2_black, p2_white;
    logic [1:0]  matchresult;
    logic [3:0]  enc_out;
    logic        enc_valid;

    int vec_count;
    int err_count;

    typedef struct {
        logic [8:0]  c1;
        logic [8:0]  c2;
        logic [3:0]  h1;
        logic [3:0]  h2;
        logic [15:0] enc;
        logic [3:0]  e_p1b;
        logic [3:0]  e_p1w;
        logic [3:0]  e_p2b;
        logic [3:0]  e_p2w;
        logic [1:0]  e_mr;
        logic [3:0]  e_eo;
        logic        e_ev;
    } vec_t;

    vec_t vecs[7];

    baw_card_eval dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .p1_card     (p1_card),
        .p2_card     (p2_card),
        .p1_handcard (p1_handcard),
        .p2_handcard (p2_handcard),
        .enc_in      (enc_in),
        .p1_black    (p1_black),
        .p1_white    (p1_white),
        .p2_black    (p2_black),
        .p2_white    (p2_white),
        .matchresult (matchresult),
        .enc_out     (enc_out),
        .enc_valid   (enc_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive inputs at the falling edge, then sample 1 time unit after the rising edge.
    task automatic applyStimulus(input logic [8:0] c1, input logic [8:0] c2,
                                 input logic [3:0] h1, input logic [3:0] h2,
                                 input logic [15:0] e);
        @(negedge clk);
        p1_card     = c1;
        p2_card     = c2;
        p1_handcard = h1;
        p2_handcard = h2;
        enc_in      = e;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [22:0] expected);
        logic [22:0] actual;
        actual = {p1_black, p1_white, p2_black, p2_white, matchresult, enc_out, enc_valid};
        vec_count++;
        if (actual !== expected) begin
            err_count++;
            $display("[TB] FAIL %s: got p1b=%0d p1w=%0d p2b=%0d p2w=%0d mr=%b eo=%0d ev=%b, expected p1b=%0d p1w=%0d p2b=%0d p2w=%0d mr=%b eo=%0d ev=%b",
                     name, actual[22:19], actual[18:15], actual[14:11], actual[10:7],
                     actual[6:5], actual[4:1], actual[0],
                     expected[22:19], expected[18:15], expected[14:11], expected[10:7],
                     expected[6:5], expected[4:1], expected[0]);
        end
    endtask

    function automatic logic [22:0] model(input logic [8:0] c1, input logic [8:0] c2,
                                          input logic [3:0] h1, input logic [3:0] h2,
                                          input logic [15:0] e);
        logic [3:0] b1, w1, b2, w2, eo;
        logic [1:0] mr;
        b1 = 4'($countones(c1 & 9'b010101010));
        w1 = 4'($countones(c1 & 9'b101010101));
        b2 = 4'($countones(c2 & 9'b010101010));
        w2 = 4'($countones(c2 & 9'b101010101));
        mr = (h1 == h2) ? 2'b00 : ((h1 > h2) ? 2'b01 : 2'b10);
        eo = 4'd0;
        for (int k = 15; k >= 0; k--) begin
            if (e[k] && eo == 4'd0 && !(|(e >> (k + 1)))) eo = 4'(k);
        end
        return {b1, w1, b2, w2, mr, eo, |e};
    endfunction

    task automatic checkSum(input string name, input logic [3:0] b, input logic [3:0] w,
                            input logic [8:0] mask);
        vec_count++;
        if ((b + w) !== 4'($countones(mask))) begin
            err_count++;
            $display("[TB] FAIL %s: black+white=%0d, expected popcount=%0d",
                     name, b + w, $countones(mask));
        end
    endtask

    initial begin
        logic [8:0]  r1, r2;
        logic [3:0]  rh1, rh2;
        logic [15:0] re;

        vec_count = 0;
        err_count = 0;

        vecs[0] = '{9'h1FF, 9'h1FF, 4'd7,  4'd3, 16'h0100, 4'd4, 4'd5, 4'd4, 4'd5, 2'b01, 4'd8,  1'b1};
        vecs[1] = '{9'h00A, 9'h101, 4'd2,  4'd8, 16'h0005, 4'd2, 4'd0, 4'd0, 4'd2, 2'b10, 4'd2,  1'b1};
        vecs[2] = '{9'h000, 9'h000, 4'd5,  4'd5, 16'h0000, 4'd0, 4'd0, 4'd0, 4'd0, 2'b00, 4'd0,  1'b0};
        vecs[3] = '{9'h0AA, 9'h155, 4'd15, 4'd9, 16'h8000, 4'd4, 4'd0, 4'd0, 4'd5, 2'b01, 4'd15, 1'b1};
        vecs[4] = '{9'h100, 9'h002, 4'd0, 4'd15, 16'h0001, 4'd0, 4'd1, 4'd1, 4'd0, 2'b10, 4'd0,  1'b1};
        vecs[5] = '{9'h1F0, 9'h00F, 4'd9,  4'd9, 16'hFFFF, 4'd2, 4'd3, 4'd2, 4'd2, 2'b00, 4'd15, 1'b1};
        vecs[6] = '{9'h055, 9'h1AA, 4'd3,  4'd4, 16'h0200, 4'd0, 4'd4, 4'd4, 4'd1, 2'b10, 4'd9,  1'b1};

        reset_n     = 1'b0;
        p1_card     = 9'h1FF;
        p2_card     = 9'h1FF;
        p1_handcard = 4'd9;
        p2_handcard = 4'd1;
        enc_in      = 16'h4000;
        #3;
        checkOutput("reset_async", 23'd0);
        @(posedge clk);
        #1;
        checkOutput("reset_held_edge", 23'd0);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        checkOutput("reset_release_no_edge", 23'd0);
        @(posedge clk);
        #1;
        checkOutput("first_edge_after_reset",
                    {4'd4, 4'd5, 4'd4, 4'd5, 2'b01, 4'd14, 1'b1});

        // Consecutive table rows exercise back-to-back updates.
        for (int i = 0; i < 7; i++) begin
            applyStimulus(vecs[i].c1, vecs[i].c2, vecs[i].h1, vecs[i].h2, vecs[i].enc);
            checkOutput($sformatf("vec%0d", i),
                        {vecs[i].e_p1b, vecs[i].e_p1w, vecs[i].e_p2b, vecs[i].e_p2w,
                         vecs[i].e_mr, vecs[i].e_eo, vecs[i].e_ev});
        end

        // Outputs must hold until the next rising edge after inputs change.
        @(negedge clk);
        p1_card     = 9'h000;
        p2_card     = 9'h000;
        p1_handcard = 4'd0;
        p2_handcard = 4'd0;
        enc_in      = 16'h0000;
        #2;
        checkOutput("latency_hold",
                    {4'd0, 4'd4, 4'd4, 4'd1, 2'b10, 4'd9, 1'b1});
        @(posedge clk);
        #1;
        checkOutput("latency_update", 23'd0);

        // Mid-operation reset pulled between edges.
        applyStimulus(9'h1FF, 9'h0AA, 4'd12, 4'd2, 16'h0300);
        checkOutput("pre_reset", {4'd4, 4'd5, 4'd4, 4'd0, 2'b01, 4'd9, 1'b1});
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("mid_reset_async", 23'd0);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        checkOutput("mid_reset_release", 23'd0);
        @(posedge clk);
        #1;
        checkOutput("post_reset_edge", {4'd4, 4'd5, 4'd4, 4'd0, 2'b01, 4'd9, 1'b1});

        for (int n = 0; n < 1000; n++) begin
            r1  = 9'($urandom_range(0, 511));
            r2  = 9'($urandom_range(0, 511));
            rh1 = 4'($urandom_range(0, 15));
            rh2 = 4'($urandom_range(0, 15));
            case (n % 4)
                0: re = 16'h0000;
                1: re = 16'(1 << $urandom_range(0, 15));
                2: re = 16'($urandom_range(0, 511));
                default: re = 16'($urandom_range(0, 65535));
            endcase
            applyStimulus(r1, r2, rh1, rh2, re);
            checkOutput($sformatf("rand%0d", n), model(r1, r2, rh1, rh2, re));
            checkSum($sformatf("sum_p1_%0d", n), p1_black, p1_white, r1);
            checkSum($sformatf("sum_p2_%0d", n), p2_black, p2_white, r2);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
        $finish;
    end

endmodule
